ex_mdu: RTL and testbench
=========================

// Module: ex_mdu
// PURPOSE
//  Iterative RV32M/RV64M multiply/divide unit beside the single-cycle EX ALU.
//  Accepts one MUL*/DIV*/REM* op per transaction over a valid/ready handshake.
//  Computes it over multiple cycles and returns an XLEN result over a second valid/ready handshake.
//  The pipeline stalls EX while busy_o is high; flush_i (branch/jump redirect) kills in-flight work.
// PARAMETERS
//  XLEN        32   operand/result width (32 or 64)
//  CNT_W       6    iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     async active-low reset
//  req_valid_i   in   1     request valid
//  req_ready_o   out  1     unit can accept a request
//  req_op_i      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  req_rs1_i     in   XLEN  operand A (multiplicand / dividend)
//  req_rs2_i     in   XLEN  operand B (multiplier / divisor)
//  flush_i       in   1     abort current op, return to IDLE
//  resp_valid_o  out  1     result valid
//  resp_ready_i  in   1     consumer takes result
//  resp_data_o   out  XLEN  result
//  busy_o        out  1     state != IDLE
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-low.
//   All state is reset by rst_n low at any time, including mid-operation.
//  Reset values: state=IDLE; req_ready_o=1; resp_valid_o=0; resp_data_o=0; busy_o=0.
//  FSM states: IDLE, CALC, FIX, DONE.
//   IDLE->CALC: on accept (req_valid_i & req_ready_o), normal op.
//   IDLE->FIX: on accept, special case (div by zero, signed overflow).
//   CALC->FIX: when iteration counter reaches XLEN-1.
//   FIX->DONE: unconditional.
//   DONE->IDLE: on resp_valid_o & resp_ready_i.
//   any->IDLE: flush_i (priority over every other transition).
//  Handshakes:
//   req_ready_o = (state==IDLE) & ~flush_i; a request presented with flush_i is not accepted.
//   resp_valid_o = (state==DONE).
//   resp_data_o is registered and stable while resp_valid_o & ~resp_ready_i.
//  Accept cycle: latch op. Latch |rs1| and |rs2| per signedness:
//   MULH, DIV, REM: both operands signed.
//   MULHSU: rs1 signed, rs2 unsigned.
//   others: both unsigned.
//   Record the result sign: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
//  CALC multiply: radix-2 shift-add into a 2*XLEN accumulator, one bit per cycle, XLEN cycles.
//  CALC divide: restoring, one quotient bit per cycle, XLEN cycles.
//   Datapath: XLEN+1-bit partial remainder.
//  FIX: two's-complement negate if the sign flag is set, then select:
//   MUL: low XLEN bits.
//   MULH*: high XLEN bits.
//   DIV*: quotient.
//   REM*: remainder.
//   Register the selection into resp_data_o.
//  Latency: with accept in cycle N:
//   normal: resp_valid_o first high in N+XLEN+2.
//   special case: resp_valid_o first high in N+2.
//  Special cases (RISC-V spec), detected in the accept cycle; CALC skipped:
//   divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//   DIV with rs1==-2^(XLEN-1) and rs2==-1: DIV -> rs1; REM -> 0.
//  Boundaries:
//   flush_i in DONE: the result is discarded; resp_valid_o is low in the next cycle.
//   flush_i in IDLE: no effect other than blocking acceptance.
//   No new request is accepted in the DONE cycle that hands off; one-cycle bubble between ops.
//   Counter is cleared on accept and on flush; no wrap is possible.
// STRUCTURE
//  Shared defines header (with existing `XLEN and OP_INFO defines) holds:
//   MDU funct3 encodings `MDU_OP_*.
//   FSM state encodings.
//  One sub-module: mdu_iter_step, a combinational single-bit step.
//   Multiply: add+shift. Divide: trial subtract, select, shift.
//  ex_mdu keeps the FSM, counter, operand/accumulator registers, and FIX/select logic.
// TESTING (XLEN=32)
//  MUL 7 x -3 (0xFFFFFFFD), accept in cycle N:
//   -> resp_data 0xFFFFFFEB; resp_valid first high in N+34.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000.
//   MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/2 -> 3; REMU 7/2 -> 1.
//  DIVU 5/0 -> 0xFFFFFFFF at N+2; REM 5/0 -> 5.
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//  resp_ready_i held low 5 cycles in DONE:
//   -> resp_valid and resp_data stable; req_ready low; busy high.
//   Then ready high -> IDLE next cycle.
//  flush_i in 10th CALC cycle -> IDLE next cycle, no resp_valid.
//   A following DIVU 100/7 returns 14.
//   rst_n low mid-CALC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - MDU_OP_*   : funct3 encodings of the RV32M/RV64M operations
//   - mdu_state_e: FSM state encodings (IDLE, CALC, FIX, DONE)
//   - helpers that decode operand signedness from funct3
package ex_mdu_pkg;

    localparam logic [2:0] MDU_OP_MUL    = 3'd0;
    localparam logic [2:0] MDU_OP_MULH   = 3'd1;
    localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
    localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
    localparam logic [2:0] MDU_OP_DIV    = 3'd4;
    localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
    localparam logic [2:0] MDU_OP_REM    = 3'd6;
    localparam logic [2:0] MDU_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one combinational iteration of the MDU datapath.
//   is_div  in   1     0: shift-add multiply step, 1: restoring divide step
//   hi      in   XLEN  upper accumulator half / partial remainder
//   lo      in   XLEN  multiplier (shifting out) / dividend->quotient
//   b       in   XLEN  multiplicand / divisor (magnitudes)
//   hi_next out  XLEN  next upper half / partial remainder
//   lo_next out  XLEN  next lower half / quotient
module mdu_iter_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          fits;

    always_comb begin
        sum     = '0;
        shifted = '0;
        trial   = '0;
        fits    = 1'b0;
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            // Partial remainder is always < divisor, so the shifted value
            // fits in XLEN+1 bits; the top bit of the trial difference is
            // the borrow that says the divisor did not fit.
            shifted = {hi, lo[XLEN-1]};
            trial   = shifted - {1'b0, b};
            fits    = ~trial[XLEN];
            hi_next = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], fits};
        end else begin
            // Add multiplicand if the current multiplier bit is set, then
            // shift the whole {carry, hi, lo} right by one.
            sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M/RV64M multiply/divide unit.
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o     request handshake
//   req_op_i                    funct3 (MUL..REMU)
//   req_rs1_i, req_rs2_i        operands
//   flush_i                     kill in-flight work, back to IDLE
//   resp_valid_o/resp_ready_i   response handshake
//   resp_data_o                 registered XLEN result
//   busy_o                      high whenever not IDLE
// Operands are converted to magnitudes on accept, iterated for XLEN
// cycles, then sign-fixed and selected in FIX. Divide-by-zero and signed
// overflow skip CALC by preloading the accumulator with the answer.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic            busy_o
);

    mdu_state_e      state_reg;
    logic [2:0]      op_reg;
    logic            neg_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0] hi_reg;
    logic [XLEN-1:0] lo_reg;
    logic [XLEN-1:0] b_reg;

    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;

    // Accept-cycle decode
    logic            accept;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            div_ovf;

    // FIX-stage sign correction
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quot_fixed;
    logic [XLEN-1:0]   rem_fixed;
    logic [XLEN-1:0]   result;

    assign req_ready_o  = (state_reg == ST_IDLE) && !flush_i;
    assign resp_valid_o = (state_reg == ST_DONE);
    assign busy_o       = (state_reg != ST_IDLE);
    assign accept       = req_valid_i && req_ready_o;

    always_comb begin
        a_neg    = op_a_signed(req_op_i) && req_rs1_i[XLEN-1];
        b_neg    = op_b_signed(req_op_i) && req_rs2_i[XLEN-1];
        a_abs    = a_neg ? -req_rs1_i : req_rs1_i;
        b_abs    = b_neg ? -req_rs2_i : req_rs2_i;
        div_zero = req_op_i[2] && (req_rs2_i == '0);
        div_ovf  = ((req_op_i == MDU_OP_DIV) || (req_op_i == MDU_OP_REM)) &&
                   (req_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (req_rs2_i == '1);
    end

    mdu_iter_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_reg[2]),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .b       (b_reg),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_comb begin
        prod       = {hi_reg, lo_reg};
        prod_fixed = neg_reg ? -prod : prod;
        quot_fixed = neg_reg ? -lo_reg : lo_reg;
        rem_fixed  = neg_reg ? -hi_reg : hi_reg;
        result     = '0;
        case (op_reg)
            MDU_OP_MUL:                          result = prod_fixed[XLEN-1:0];
            MDU_OP_MULH, MDU_OP_MULHSU,
            MDU_OP_MULHU:                        result = prod_fixed[2*XLEN-1:XLEN];
            MDU_OP_DIV, MDU_OP_DIVU:             result = quot_fixed;
            default:                             result = rem_fixed;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            op_reg      <= MDU_OP_MUL;
            neg_reg     <= 1'b0;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            b_reg       <= '0;
            resp_data_o <= '0;
        end else if (flush_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg  <= req_op_i;
                        cnt_reg <= '0;
                        b_reg   <= b_abs;
                        if (div_zero || div_ovf) begin
                            // Preload so FIX selects the architectural answer:
                            // quotient from lo, remainder from hi, no negate.
                            state_reg <= ST_FIX;
                            neg_reg   <= 1'b0;
                            if (div_zero) begin
                                lo_reg <= '1;
                                hi_reg <= req_rs1_i;
                            end else begin
                                lo_reg <= req_rs1_i;
                                hi_reg <= '0;
                            end
                        end else begin
                            state_reg <= ST_CALC;
                            hi_reg    <= '0;
                            lo_reg    <= a_abs;
                            // Remainder takes the dividend's sign only.
                            neg_reg   <= (req_op_i[2] && req_op_i[1]) ? a_neg : (a_neg ^ b_neg);
                        end
                    end
                end
                ST_CALC: begin
                    hi_reg  <= hi_next;
                    lo_reg  <= lo_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(XLEN-1)) begin
                        state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    resp_data_o <= result;
                    state_reg   <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed and scoreboard-checked test of ex_mdu at XLEN=32.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = 3'd0;
    logic [XLEN-1:0] req_rs1 = '0;
    logic [XLEN-1:0] req_rs2 = '0;
    logic            flush = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_data;
    logic            busy;

    int total = 0;
    int bad   = 0;
    logic [XLEN-1:0] sb_q[$];

    always #5 clk = ~clk;

    ex_mdu #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .flush_i      (flush),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference using wide native arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        int          q;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p = '0;
        q = 0;
        case (op)
            MDU_OP_MUL:    begin p = ua * ub; return p[31:0];  end
            MDU_OP_MULH:   begin p = sa * sb; return p[63:32]; end
            MDU_OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            MDU_OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            MDU_OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                q = $signed(a) / $signed(b);
                return q;
            end
            MDU_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MDU_OP_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drive one request, wait for the response, optionally stall it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int stall);
        logic [31:0] e;
        int k;
        sb_q.push_back(exp);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        check("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1;
        while (!resp_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, lat);
        e = sb_q.pop_front();
        check("resp_data", resp_data, e);
        $display("op=%0d rs1=%h rs2=%h data=%h exp=%h lat=%0d", op, a, b, resp_data, e, k);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid", resp_valid, 1);
            check("stall_data", resp_data, e);
            check("stall_req_ready", req_ready, 0);
            check("stall_busy", busy, 1);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("idle_after_handoff", {busy, resp_valid}, 0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        logic        seen;

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiply variants
        run_op(MDU_OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        run_op(MDU_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op(MDU_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run_op(MDU_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);

        // Divide variants
        run_op(MDU_OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op(MDU_OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op(MDU_OP_DIVU, 32'd7,         32'd2, 32'd3,         34, 0);
        run_op(MDU_OP_REMU, 32'd7,         32'd2, 32'd1,         34, 0);

        // Special cases skip CALC
        run_op(MDU_OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2, 0);
        run_op(MDU_OP_REM,  32'd5,         32'd0,         32'd5,         2, 0);
        run_op(MDU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
        run_op(MDU_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2, 0);

        // Random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(7, 0));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd13 : $urandom;
            run_op(rop, ra, rb, model(rop, ra, rb), 34, 0);
        end

        // Response back-pressure for 5 cycles
        run_op(MDU_OP_MUL, 32'd123, 32'd456, 32'd56088, 34, 5);

        // flush in IDLE blocks acceptance only
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = MDU_OP_DIVU;
        req_rs1   = 32'd9;
        req_rs2   = 32'd3;
        #1;
        check("flush_idle_ready", req_ready, 0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_idle_busy", busy, 0);

        // flush in the 10th CALC cycle
        req_valid = 1'b1;
        req_op    = MDU_OP_DIVU;
        req_rs1   = 32'd1000;
        req_rs2   = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("busy_before_flush", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc_busy", busy, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check("flush_no_resp", seen, 0);
        run_op(MDU_OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);

        // Asynchronous reset mid-CALC
        req_valid = 1'b1;
        req_op    = MDU_OP_MUL;
        req_rs1   = 32'd3;
        req_rs2   = 32'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("busy_before_reset", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_resp_valid", resp_valid, 0);
        check("arst_resp_data", resp_data, 0);
        check("arst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(MDU_OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0,
               model(MDU_OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 34, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
